// File: rtl/uart_tx_serializer_if.sv
// Word handshake between the UART register file (source) and the TX serializer (sink).
interface uart_tx_serializer_if #(
  parameter int MAX_DATA = 8
) ();
  logic [MAX_DATA-1:0] txData;
  logic                txValid;
  logic                txReady;

  modport master (output txData, output txValid, input txReady);
  modport slave  (input txData, input txValid, output txReady);
endinterface

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: start, 5..8 data bits LSB-first, optional parity, 1 or 2 stop bits.
// Build with UART_PARITY_EN defined to include the parity bit; otherwise parity inputs are ignored.
module uart_tx_serializer #(
  parameter int DIV_WIDTH = 16,
  parameter int MAX_DATA  = 8
) (
  input  logic                 clock_50MHz,
  input  logic                 reset,
  input  logic [DIV_WIDTH-1:0] baudDivisor,
  input  logic [1:0]           dataBits,
  input  logic                 stopBits,
  input  logic                 parityEnable,
  input  logic                 parityOdd,
  uart_tx_serializer_if.slave  tx,
  output logic                 txBusy,
  output logic                 txDone,
  output logic                 txOut
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t               state_q, state_d;
  logic [DIV_WIDTH-1:0] baud_q;
  logic [DIV_WIDTH-1:0] div_last_q;
  logic [2:0]           bit_q;
  logic [2:0]           last_bit_q;
  logic                 two_stop_q;
  logic                 stop_q;
  logic [MAX_DATA-1:0]  shift_q;
  logic                 done_q;

  logic                 wrap;
  logic                 accept;
  logic                 shift_en;
  logic                 done_d;

`ifdef UART_PARITY_EN
  logic par_en_q;
  logic par_bit_q;
  logic par_calc;

  // Parity over only the N bits that will actually be sent.
  always_comb begin
    par_calc = parityOdd;
    for (int unsigned i = 0; i < MAX_DATA; i++) begin
      if (i < 32'd5 + 32'(dataBits))
        par_calc = par_calc ^ tx.txData[i];
    end
  end
`else
  logic unused_parity_cfg;
  assign unused_parity_cfg = parityEnable ^ parityOdd;
`endif

  // div_last_q holds max(div,1)-1 so the wrap compare never needs div+1.
  assign wrap = (baud_q == div_last_q);

  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    shift_en = 1'b0;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (tx.txValid) begin
          accept  = 1'b1;
          state_d = S_START;
        end
      end
      S_START: begin
        if (wrap) state_d = S_DATA;
      end
      S_DATA: begin
        if (wrap) begin
          shift_en = 1'b1;
          if (bit_q == last_bit_q) begin
`ifdef UART_PARITY_EN
            state_d = par_en_q ? S_PARITY : S_STOP;
`else
            state_d = S_STOP;
`endif
          end
        end
      end
`ifdef UART_PARITY_EN
      S_PARITY: begin
        if (wrap) state_d = S_STOP;
      end
`endif
      S_STOP: begin
        if (wrap && !(two_stop_q && !stop_q)) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    txOut = 1'b1;
    case (state_q)
      S_START: txOut = 1'b0;
      S_DATA:  txOut = shift_q[0];
`ifdef UART_PARITY_EN
      S_PARITY: txOut = par_bit_q;
`endif
      default: txOut = 1'b1;
    endcase
  end

  assign tx.txReady = (state_q == S_IDLE);
  assign txBusy     = (state_q != S_IDLE);
  assign txDone     = done_q;

  always_ff @(posedge clock_50MHz or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      baud_q     <= '0;
      div_last_q <= '0;
      bit_q      <= '0;
      last_bit_q <= '0;
      two_stop_q <= 1'b0;
      stop_q     <= 1'b0;
      shift_q    <= '0;
      done_q     <= 1'b0;
`ifdef UART_PARITY_EN
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      if (accept) begin
        baud_q     <= '0;
        div_last_q <= (baudDivisor == '0) ? '0 : baudDivisor - DIV_WIDTH'(1);
        bit_q      <= '0;
        last_bit_q <= 3'd4 + {1'b0, dataBits};
        two_stop_q <= stopBits;
        stop_q     <= 1'b0;
        shift_q    <= tx.txData;
`ifdef UART_PARITY_EN
        par_en_q   <= parityEnable;
        par_bit_q  <= par_calc;
`endif
      end else if (state_q != S_IDLE) begin
        baud_q <= wrap ? '0 : baud_q + DIV_WIDTH'(1);
        if (shift_en) begin
          shift_q <= shift_q >> 1;
          bit_q   <= bit_q + 3'd1;
        end
        if (state_q == S_STOP && wrap)
          stop_q <= 1'b1;
      end
    end
  end

endmodule
